// File: rtl/target_row_streamer_pkg.sv
// Shared definitions for the target-sequence row streamer: base encoding, default
// target SRAM geometry and the control FSM state type.
package target_pkg;

    localparam int unsigned BASE_W = 2;

    localparam logic [BASE_W-1:0] BASE_A = 2'b00;
    localparam logic [BASE_W-1:0] BASE_C = 2'b01;
    localparam logic [BASE_W-1:0] BASE_G = 2'b10;
    localparam logic [BASE_W-1:0] BASE_T = 2'b11;

    localparam int unsigned TGT_DEPTH      = 18;
    localparam int unsigned TGT_WIDTHS     = 1920;
    localparam int unsigned TGT_ADDR_WIDTH = 5;
    localparam int unsigned TGT_OUT_W      = 64;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StStream,
        StFin
    } state_e;

endpackage

// File: rtl/target_row_streamer_if.sv
// Valid/ready beat stream carrying packed target bases plus the source row of each beat.
interface target_row_streamer_if #(
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [ADDR_WIDTH-1:0] out_row;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/target_row_streamer_row_buffer.sv
// Holds one full SRAM row and selects the beat addressed by beat_idx_i,
// keeping the wide datapath out of the control FSM.
module target_row_buffer #(
    parameter int unsigned WIDTHS = 1920,
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned BEAT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WIDTHS-1:0] row_i,
    input  logic [BEAT_W-1:0] beat_idx_i,
    output logic [OUT_W-1:0]  beat_o
);
    logic [WIDTHS-1:0] row_q, row_d;

    always_comb begin
        row_d = row_q;
        if (load_i) row_d = row_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row_q <= '0;
        else        row_q <= row_d;
    end

    // Least-significant beat of the row goes out first.
    assign beat_o = row_q[beat_idx_i * OUT_W +: OUT_W];
endmodule

// File: rtl/target_row_streamer.sv
// Fetches a range of target SRAM rows and serialises each row into OUT_W-bit beats
// of packed 2-bit bases for the alignment engine.
module target_row_streamer
    import target_pkg::*;
#(
    parameter int unsigned DEPTH      = TGT_DEPTH,
    parameter int unsigned WIDTHS     = TGT_WIDTHS,
    parameter int unsigned ADDR_WIDTH = TGT_ADDR_WIDTH,
    parameter int unsigned OUT_W      = TGT_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_row,
    input  logic [ADDR_WIDTH:0]   num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rEn,
    output logic [ADDR_WIDTH-1:0] mem_rAddr,
    input  logic [WIDTHS-1:0]     mem_rData,
    target_row_streamer_if.master strm
);
    localparam int unsigned BEATS  = WIDTHS / OUT_W;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d;
    logic [ADDR_WIDTH:0]   rows_left_q, rows_left_d;
    logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ren_q, ren_d;
    logic                  valid_q, valid_d;

    logic                  buf_load;
    logic [OUT_W-1:0]      beat_data;
    logic                  last_beat;
    logic                  last_row;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] row_next;

    assign last_beat = (beat_idx_q == BEAT_W'(BEATS - 1));
    assign last_row  = (rows_left_q == (ADDR_WIDTH + 1)'(1));
    assign handshake = valid_q & strm.out_ready;
    // Row pointer wraps at the physical depth, not at the address-space limit.
    assign row_next  = (row_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : row_ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        rows_left_d = rows_left_q;
        beat_idx_d  = beat_idx_q;
        raddr_d     = raddr_q;
        buf_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_rows == '0) begin
                        state_d = StFin;
                    end else begin
                        row_ptr_d   = first_row;
                        rows_left_d = num_rows;
                        raddr_d     = first_row;
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                buf_load   = 1'b1;
                beat_idx_d = '0;
                state_d    = StStream;
            end
            StStream: begin
                if (handshake) begin
                    if (!last_beat) begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end else begin
                        rows_left_d = rows_left_q - 1'b1;
                        if (last_row) begin
                            state_d = StFin;
                        end else begin
                            row_ptr_d = row_next;
                            raddr_d   = row_next;
                            state_d   = StFetch;
                        end
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered: they follow the state being entered.
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StFin);
        ren_d   = (state_d == StFetch);
        valid_d = (state_d == StStream);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_ptr_q   <= '0;
            rows_left_q <= '0;
            beat_idx_q  <= '0;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ren_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            rows_left_q <= rows_left_d;
            beat_idx_q  <= beat_idx_d;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ren_q       <= ren_d;
            valid_q     <= valid_d;
        end
    end

    target_row_buffer #(
        .WIDTHS (WIDTHS),
        .OUT_W  (OUT_W),
        .BEAT_W (BEAT_W)
    ) u_row_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (buf_load),
        .row_i      (mem_rData),
        .beat_idx_i (beat_idx_q),
        .beat_o     (beat_data)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_rEn        = ren_q;
    assign mem_rAddr      = raddr_q;
    assign strm.out_valid = valid_q;
    assign strm.out_data  = valid_q ? beat_data : '0;
    assign strm.out_row   = valid_q ? row_ptr_q : '0;
    assign strm.out_last  = valid_q & last_beat & last_row;
endmodule
